// File: rtl/router_pkg.sv
// Shared router types and default sizing for the output channel.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package router_pkg;

    localparam int DATA_SIZE       = 8;
    localparam int PKT_LENGTH_BITS = 5;
    localparam int TIMEOUT_CYCLES  = 30;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_SEND  = 3'd3,
        S_DROP  = 3'd4
    } e_output_channel_state;

endpackage

// File: rtl/out_channel_fsm_wdog.sv
// Stall watchdog: counts consecutive stalled cycles, flags expiry on the last one.
// Latency: expired is combinational in the timeout_cycles-th counted cycle.
// Backpressure: none; clr has priority over count_en.
module out_ch_wdog #(
    parameter int timeout_cycles = router_pkg::TIMEOUT_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic count_en,
    input  logic clr,
    output logic expired
);

    localparam int CW = $clog2(timeout_cycles + 1);

    logic [CW-1:0] stall_cnt;

    assign expired = count_en && (stall_cnt == CW'(timeout_cycles - 1));

    // Count stalled cycles; hold at the expiry value until the owner leaves the stall.
    always_ff @(posedge i_clk) begin
        if (i_rst || clr) begin
            stall_cnt <= '0;
        end else if (count_en && !expired) begin
            stall_cnt <= stall_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/out_channel_fsm.sv
// Output channel: pops packet bytes from a FIFO and forwards them, checks length/parity, aborts on stall.
// Latency: 3 cycles FIFO-not-empty to o_valid per byte (fetch, load, send).
// Backpressure: o_valid/o_data held until i_ready; timeout_cycles of stall drops the rest of the packet.
module out_channel_fsm
    import router_pkg::*;
#(
    parameter int data_size       = DATA_SIZE,
    parameter int pkt_length_bits = PKT_LENGTH_BITS,
    parameter int timeout_cycles  = TIMEOUT_CYCLES
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_fifo_empty,
    input  logic [data_size-1:0] i_fifo_data,
    output logic                 o_fifo_rd_en,
    input  logic                 i_ready,
    output logic                 o_valid,
    output logic [data_size-1:0] o_data,
    input  logic                 i_clr_errors,
    output logic                 o_busy,
    output logic                 o_error,
    output logic [2:0]           o_err_flags
);

    typedef logic [pkt_length_bits:0] cnt_t;

    e_output_channel_state      state, state_nxt;
    cnt_t                       byte_cnt;
    logic [pkt_length_bits-1:0] len_q;
    logic [data_size-1:0]       xor_acc;

    cnt_t                       pkt_total;
    cnt_t                       cnt_inc;
    logic [pkt_length_bits-1:0] hdr_len;
    logic                       is_hdr;
    logic                       is_parity_load;
    logic                       drop_pop;
    logic                       handshake;
    logic                       wdog_expired;
    logic                       set_len, set_par, set_to;

    // A zero-length header still carries a parity byte, so the minimum total is 2.
    assign pkt_total      = (len_q == '0) ? cnt_t'(2) : ({1'b0, len_q} + cnt_t'(2));
    assign cnt_inc        = byte_cnt + cnt_t'(1);
    assign hdr_len        = i_fifo_data[pkt_length_bits+2:3];
    assign is_hdr         = (byte_cnt == '0);
    assign is_parity_load = !is_hdr && (cnt_inc == pkt_total);
    assign handshake      = (state == S_SEND) && i_ready;
    assign drop_pop       = (state == S_DROP) && !i_fifo_empty && (byte_cnt != pkt_total);

    assign o_fifo_rd_en = ((state == S_FETCH) && !i_fifo_empty) || drop_pop;
    assign o_valid      = (state == S_SEND);
    assign o_busy       = (state != S_IDLE);
    assign o_error      = |o_err_flags;

    assign set_len = (state == S_LOAD) && is_hdr && (hdr_len == '0);
    assign set_par = (state == S_LOAD) && is_parity_load && (i_fifo_data != xor_acc);
    assign set_to  = wdog_expired;

    out_ch_wdog #(
        .timeout_cycles(timeout_cycles)
    ) u_wdog (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .count_en((state == S_SEND) && !i_ready),
        .clr     ((state != S_SEND) || i_ready),
        .expired (wdog_expired)
    );

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!i_fifo_empty) state_nxt = S_FETCH;
            S_FETCH: if (!i_fifo_empty) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_SEND;
            S_SEND: begin
                if (wdog_expired) begin
                    state_nxt = S_DROP;
                end else if (i_ready) begin
                    state_nxt = (byte_cnt == pkt_total) ? S_IDLE : S_FETCH;
                end
            end
            S_DROP: begin
                if ((byte_cnt == pkt_total) || (drop_pop && (cnt_inc == pkt_total))) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Byte capture, byte counting, length latch and running parity.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_data   <= '0;
            byte_cnt <= '0;
            len_q    <= '0;
            xor_acc  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    byte_cnt <= '0;
                    len_q    <= '0;
                    xor_acc  <= '0;
                end
                S_LOAD: begin
                    o_data   <= i_fifo_data;
                    byte_cnt <= cnt_inc;
                    if (is_hdr) begin
                        len_q   <= hdr_len;
                        xor_acc <= i_fifo_data;
                    end else if (!is_parity_load) begin
                        xor_acc <= xor_acc ^ i_fifo_data;
                    end
                end
                S_DROP: if (drop_pop) byte_cnt <= cnt_inc;
                default: ;
            endcase
        end
    end

    // Sticky error flags; a new error in the same cycle as a clear wins.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_err_flags <= '0;
        end else begin
            o_err_flags <= (i_clr_errors ? 3'b000 : o_err_flags) | {set_to, set_par, set_len};
        end
    end

endmodule

// File: tb/tb_out_channel_fsm.sv
module tb_out_channel_fsm;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_fifo_empty = 1'b1;
    logic [7:0] i_fifo_data = 8'h00;
    logic       o_fifo_rd_en;
    logic       i_ready = 1'b0;
    logic       o_valid;
    logic [7:0] o_data;
    logic       i_clr_errors = 1'b0;
    logic       o_busy;
    logic       o_error;
    logic [2:0] o_err_flags;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];

    out_channel_fsm #(
        .data_size(8),
        .pkt_length_bits(5),
        .timeout_cycles(30)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_fifo_empty(i_fifo_empty),
        .i_fifo_data (i_fifo_data),
        .o_fifo_rd_en(o_fifo_rd_en),
        .i_ready     (i_ready),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .i_clr_errors(i_clr_errors),
        .o_busy      (o_busy),
        .o_error     (o_error),
        .o_err_flags (o_err_flags)
    );

    always #5 i_clk = ~i_clk;

    // FIFO model: a pop seen at an edge presents data just after that edge.
    initial begin
        logic pop;
        forever begin
            @(posedge i_clk);
            pop = o_fifo_rd_en;
            #1;
            if (pop && fifo_q.size() > 0) begin
                i_fifo_data  = fifo_q.pop_front();
                i_fifo_empty = (fifo_q.size() == 0);
            end
        end
    end

    // Scoreboard: every accepted output byte must match the next expected byte.
    initial begin
        logic [7:0] exp_b;
        forever begin
            @(negedge i_clk);
            if (o_valid && i_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL out_byte_unexpected: got %h, expected no output", o_data);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (o_data !== exp_b) begin
                        n_fail++;
                        $display("FAIL out_byte: got %h, expected %h", o_data, exp_b);
                    end
                end
            end
        end
    end

    task automatic fifo_push(input logic [7:0] b, input bit fwd);
        fifo_q.push_back(b);
        if (fwd) exp_q.push_back(b);
        i_fifo_empty = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge i_clk);
            if (exp_q.size() == 0 && !o_busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge i_clk);
            if (o_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_clear();
        @(negedge i_clk);
        i_clr_errors = 1'b1;
        @(negedge i_clk);
        i_clr_errors = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        n_checks++; if (o_valid !== 1'b0)      begin n_fail++; $display("FAIL rst_valid: got %b, expected 0", o_valid); end
        n_checks++; if (o_data !== 8'h00)      begin n_fail++; $display("FAIL rst_data: got %h, expected 00", o_data); end
        n_checks++; if (o_fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_rd_en: got %b, expected 0", o_fifo_rd_en); end
        n_checks++; if (o_busy !== 1'b0)       begin n_fail++; $display("FAIL rst_busy: got %b, expected 0", o_busy); end
        n_checks++; if (o_err_flags !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b, expected 000", o_err_flags); end
        n_checks++; if (o_error !== 1'b0)      begin n_fail++; $display("FAIL rst_error: got %b, expected 0", o_error); end
        i_rst = 1'b0;
    endtask

    task automatic test_good_packet();
        logic [7:0] par;
        bit ok;
        par = 8'h18 ^ 8'h11 ^ 8'h22 ^ 8'h33;
        i_ready = 1'b1;
        @(negedge i_clk);
        fifo_push(8'h18, 1); fifo_push(8'h11, 1); fifo_push(8'h22, 1); fifo_push(8'h33, 1); fifo_push(par, 1);
        @(negedge i_clk);
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL hdr_lat_c1: valid got %b, expected 0", o_valid); end
        @(negedge i_clk);
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL hdr_lat_c2: valid got %b, expected 0", o_valid); end
        @(negedge i_clk);
        n_checks++; if (o_valid !== 1'b1 || o_data !== 8'h18) begin n_fail++; $display("FAIL hdr_lat_c3: valid/data got %b/%h, expected 1/18", o_valid, o_data); end
        wait_idle(100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL good_drain: %0d bytes left, expected 0", exp_q.size()); end
        n_checks++; if (o_err_flags !== 3'b000 || o_error !== 1'b0) begin n_fail++; $display("FAIL good_flags: got %b/%b, expected 000/0", o_err_flags, o_error); end
    endtask

    task automatic test_parity_error();
        bit ok;
        i_ready = 1'b1;
        @(negedge i_clk);
        fifo_push(8'h18, 1); fifo_push(8'h11, 1); fifo_push(8'h22, 1); fifo_push(8'h33, 1); fifo_push(8'h31, 1);
        wait_idle(100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL par_drain: %0d bytes left, expected 0", exp_q.size()); end
        n_checks++; if (o_err_flags !== 3'b010 || o_error !== 1'b1) begin n_fail++; $display("FAIL par_flags: got %b/%b, expected 010/1", o_err_flags, o_error); end
        pulse_clear();
        n_checks++; if (o_err_flags !== 3'b000 || o_error !== 1'b0) begin n_fail++; $display("FAIL par_clear: got %b/%b, expected 000/0", o_err_flags, o_error); end
    endtask

    task automatic test_zero_length();
        bit ok;
        i_ready = 1'b1;
        @(negedge i_clk);
        fifo_push(8'h00, 1); fifo_push(8'h00, 1);
        wait_idle(50, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL zlen_drain: %0d bytes left, expected 0", exp_q.size()); end
        n_checks++; if (o_err_flags !== 3'b001) begin n_fail++; $display("FAIL zlen_flags: got %b, expected 001", o_err_flags); end
        pulse_clear();
    endtask

    task automatic test_timeout();
        logic [7:0] par;
        bit ok;
        int bad_valid;
        int stall_bad;
        par = 8'h18 ^ 8'h11 ^ 8'h22 ^ 8'h33;
        i_ready = 1'b1;
        @(negedge i_clk);
        fifo_push(8'h18, 1); fifo_push(8'h11, 0); fifo_push(8'h22, 0); fifo_push(8'h33, 0); fifo_push(par, 0);
        wait_valid(20, ok);
        n_checks++; if (!ok || o_data !== 8'h18) begin n_fail++; $display("FAIL to_hdr: valid/data got %b/%h, expected 1/18", ok, o_data); end
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        wait_valid(20, ok);
        n_checks++; if (!ok || o_data !== 8'h11) begin n_fail++; $display("FAIL to_payload: valid/data got %b/%h, expected 1/11", ok, o_data); end
        stall_bad = 0;
        for (int i = 0; i < 29; i++) begin
            @(negedge i_clk);
            if (o_valid !== 1'b1) stall_bad++;
        end
        n_checks++; if (stall_bad != 0) begin n_fail++; $display("FAIL to_hold: valid dropped in %0d of 29 cycles, expected 0", stall_bad); end
        @(negedge i_clk);
        n_checks++; if (o_valid !== 1'b0 || o_err_flags !== 3'b100) begin n_fail++; $display("FAIL to_abort: valid/flags got %b/%b, expected 0/100", o_valid, o_err_flags); end
        i_ready = 1'b1;
        bad_valid = 0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (o_valid) bad_valid++;
            if (!o_busy) begin ok = 1'b1; break; end
            @(negedge i_clk);
        end
        n_checks++; if (!ok || bad_valid != 0) begin n_fail++; $display("FAIL to_drop: idle=%b valid_cycles=%0d, expected 1/0", ok, bad_valid); end
        n_checks++; if (fifo_q.size() != 0) begin n_fail++; $display("FAIL to_flush: fifo holds %0d, expected 0", fifo_q.size()); end
        @(negedge i_clk);
        fifo_push(8'h18, 1); fifo_push(8'h11, 1); fifo_push(8'h22, 1); fifo_push(8'h33, 1); fifo_push(par, 1);
        wait_idle(100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL to_next_pkt: %0d bytes left, expected 0", exp_q.size()); end
        n_checks++; if (o_err_flags !== 3'b100) begin n_fail++; $display("FAIL to_sticky: got %b, expected 100", o_err_flags); end
        pulse_clear();
    endtask

    task automatic test_fifo_stall();
        logic [7:0] par;
        bit ok;
        int bad;
        par = 8'h18 ^ 8'h11 ^ 8'h22 ^ 8'h33;
        i_ready = 1'b1;
        @(negedge i_clk);
        fifo_push(8'h18, 1); fifo_push(8'h11, 1);
        repeat (8) @(negedge i_clk);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            if (o_fifo_rd_en !== 1'b0 || o_busy !== 1'b1 || o_valid !== 1'b0 || o_err_flags !== 3'b000) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL fstall_wait: %0d bad cycles, expected 0", bad); end
        fifo_push(8'h22, 1); fifo_push(8'h33, 1); fifo_push(par, 1);
        wait_idle(100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL fstall_resume: %0d bytes left, expected 0", exp_q.size()); end
        n_checks++; if (o_err_flags !== 3'b000) begin n_fail++; $display("FAIL fstall_flags: got %b, expected 000", o_err_flags); end
    endtask

    task automatic test_reset_mid_send();
        bit ok;
        i_ready = 1'b1;
        @(negedge i_clk);
        fifo_push(8'h00, 1); fifo_push(8'h00, 1);
        wait_idle(50, ok);
        n_checks++; if (o_err_flags !== 3'b001) begin n_fail++; $display("FAIL rsend_pre: got %b, expected 001", o_err_flags); end
        i_ready = 1'b0;
        fifo_push(8'h18, 0); fifo_push(8'h11, 0); fifo_push(8'h22, 0); fifo_push(8'h33, 0); fifo_push(8'h18, 0);
        wait_valid(20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rsend_valid: got %b, expected 1", ok); end
        i_rst = 1'b1;
        @(negedge i_clk);
        n_checks++; if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_err_flags !== 3'b000) begin n_fail++; $display("FAIL rsend_state: valid/busy/flags got %b/%b/%b, expected 0/0/000", o_valid, o_busy, o_err_flags); end
        i_rst = 1'b0;
        // The byte left at the FIFO head (0x11) now acts as a header: length 2, so 4 bytes.
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33); exp_q.push_back(8'h18);
        i_ready = 1'b1;
        wait_idle(100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rsend_rehdr: %0d bytes left, expected 0", exp_q.size()); end
        n_checks++; if (o_err_flags !== 3'b010) begin n_fail++; $display("FAIL rsend_par: got %b, expected 010", o_err_flags); end
    endtask

    initial begin
        test_reset();
        test_good_packet();
        test_parity_error();
        test_zero_length();
        test_timeout();
        test_fifo_stall();
        test_reset_mid_send();
        repeat (2) @(negedge i_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit, expected completion");
        $fatal(1, "global timeout");
    end

endmodule
